// File: rtl/scaler_horiz.sv
// rtl/scaler_horiz.sv - horizontal 2-tap linear-interpolating video scaler, 4.12 step, 3-clock latency
module scaler_horiz #(
  parameter int TABLE_INPUT_WIDTH = 10,
  parameter int PIXEL_STEP        = 4096,
  parameter int DATA_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           scale_step,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  localparam int T  = TABLE_INPUT_WIDTH;
  localparam int LG = $clog2(PIXEL_STEP);
  localparam int SH = LG - T;
  localparam int PW = DATA_WIDTH + T + 1;

  logic [11:0]           in_cnt_q, in_cnt_d;
  logic [27:0]           out_pos_q, out_pos_d;
  logic [15:0]           step_q, step_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] p0_q, p0_d, p1_q, p1_d;

  logic                  v1_q, v1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [DATA_WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [T:0]            c1_q, c1_d;

  logic                  v2_q, v2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [PW-1:0]         acc2_q, acc2_d;

  logic [DATA_WIDTH-1:0] do_q, do_d;
  logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  logic [27:0]           k_cur, limit, base, frac, nxt;
  logic                  act, emit;
  logic [T:0]            c_cur, wa;
  logic [DATA_WIDTH-1:0] e_p0, e_p1;
  logic [PW-1:0]         shifted;

  // Iterator: one output per clock while out_pos has not passed input pixel k.
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_pos_d = out_pos_q;
    step_d    = step_q;
    busy_d    = busy_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    act       = 1'b0;
    emit      = 1'b0;
    e_p0      = p0_q;
    e_p1      = p1_q;
    c_cur     = '0;
    k_cur     = 28'(in_cnt_q) - 28'd1;
    if (hs_i) begin
      in_cnt_d  = '0;
      out_pos_d = '0;
      busy_d    = 1'b0;
      step_d    = (scale_step == 16'd0) ? 16'(PIXEL_STEP) : scale_step;
    end else if (busy_q) begin
      act = 1'b1;
    end else if (de_i) begin
      in_cnt_d = in_cnt_q + 12'd1;
      p1_d     = di_i;
      if (in_cnt_q == 12'd0) begin
        emit      = 1'b1;
        e_p0      = di_i;
        e_p1      = di_i;
        out_pos_d = out_pos_q + 28'(step_q);
      end else begin
        p0_d  = p1_q;
        e_p0  = p1_q;
        e_p1  = di_i;
        k_cur = 28'(in_cnt_q);
        act   = 1'b1;
      end
    end
    limit = k_cur << LG;
    base  = (k_cur - 28'd1) << LG;
    frac  = out_pos_q - base;
    nxt   = out_pos_q + 28'(step_q);
    if (act) begin
      if (out_pos_q <= limit) begin
        emit      = 1'b1;
        c_cur     = (T+1)'(frac >> SH);
        out_pos_d = nxt;
        busy_d    = (nxt <= limit);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_comb begin
    v1_d  = emit;
    a1_d  = e_p0;
    b1_d  = e_p1;
    c1_d  = c_cur;
    hs1_d = hs_i;
    vs1_d = vs_i;

    wa     = (T+1)'(1 << T) - c1_q;
    v2_d   = v1_q;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    acc2_d = PW'(a1_q) * PW'(wa) + PW'(b1_q) * PW'(c1_q) + PW'(1 << (T - 1));

    shifted = acc2_q >> T;
    de_d    = v2_q & ~hs2_q;
    hs_d    = hs2_q;
    vs_d    = vs2_q;
    do_d    = do_q;
    if (de_d) begin
      do_d = (|shifted[PW-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_q  <= '0;
      out_pos_q <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      p0_q      <= '0;
      p1_q      <= '0;
      v1_q      <= 1'b0;
      a1_q      <= '0;
      b1_q      <= '0;
      c1_q      <= '0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      v2_q      <= 1'b0;
      acc2_q    <= '0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      do_q      <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_pos_q <= out_pos_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      v1_q      <= v1_d;
      a1_q      <= a1_d;
      b1_q      <= b1_d;
      c1_q      <= c1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      v2_q      <= v2_d;
      acc2_q    <= acc2_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      do_q      <= do_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign do_o = do_q;
  assign de_o = de_q;
  assign hs_o = hs_q;
  assign vs_o = vs_q;

endmodule

// File: tb/tb_scaler_horiz.sv
// tb/tb_scaler_horiz.sv - directed self-checking bench for scaler_horiz
module tb_scaler_horiz;

  localparam int HMAX = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] scale_step;
  logic [7:0]  di_i;
  logic        de_i, hs_i, vs_i;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int out_q[$];
  int ocyc_q[$];
  int in_cyc_q[$];

  bit hs_in_h [HMAX];
  bit vs_in_h [HMAX];
  bit hs_out_h[HMAX];
  bit vs_out_h[HMAX];
  bit de_out_h[HMAX];

  scaler_horiz dut (
    .clk(clk), .rst(rst), .scale_step(scale_step), .di_i(di_i), .de_i(de_i),
    .hs_i(hs_i), .vs_i(vs_i), .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (de_o) begin
      out_q.push_back(int'(do_o));
      ocyc_q.push_back(cyc);
    end
    if (cyc < HMAX) begin
      hs_in_h[cyc]  <= hs_i;
      vs_in_h[cyc]  <= vs_i;
      hs_out_h[cyc] <= hs_o;
      vs_out_h[cyc] <= vs_o;
      de_out_h[cyc] <= de_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input logic [15:0] step, input int w, input int gap,
                            input int base, input logic vs_pre);
    out_q.delete();
    ocyc_q.delete();
    in_cyc_q.delete();
    scale_step = step;
    hs_i = 1'b1;
    vs_i = vs_pre;
    de_i = 1'b0;
    repeat (4) tick();
    hs_i = 1'b0;
    vs_i = 1'b0;
    for (int k = 0; k < w; k++) begin
      de_i = 1'b1;
      di_i = 8'(base + k);
      in_cyc_q.push_back(cyc);
      tick();
      de_i = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
    de_i = 1'b0;
    hs_i = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    scale_step = 16'd4096;
    di_i = 8'd0;
    de_i = 1'b0;
    hs_i = 1'b1;
    vs_i = 1'b1;
    #1;
    n_checks++;
    if ({do_o, de_o, hs_o, vs_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got do=%0d de=%0b hs=%0b vs=%0b, want all 0", do_o, de_o, hs_o, vs_o);
    end
    repeat (4) tick();
    n_checks++;
    if ({de_o, hs_o, vs_o} !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_held: got de=%0b hs=%0b vs=%0b, want 0", de_o, hs_o, vs_o);
    end
    rst = 1'b1;
    vs_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_unity();
    drive_line(16'd4096, 24, 1, 0, 1'b0);
    n_checks++;
    if (out_q.size() != 24) begin
      n_fail++;
      $display("FAIL unity_count: got %0d, want 24", out_q.size());
    end else begin
      for (int j = 0; j < 24; j++) begin
        n_checks++;
        if (out_q[j] != j) begin
          n_fail++;
          $display("FAIL unity_val[%0d]: got %0d, want %0d", j, out_q[j], j);
        end
        n_checks++;
        if (ocyc_q[j] - in_cyc_q[j] != 3) begin
          n_fail++;
          $display("FAIL unity_latency[%0d]: got %0d, want 3", j, ocyc_q[j] - in_cyc_q[j]);
        end
      end
    end
  endtask

  task automatic test_zero_step();
    drive_line(16'd0, 24, 1, 100, 1'b0);
    n_checks++;
    if (out_q.size() != 24) begin
      n_fail++;
      $display("FAIL zero_step_count: got %0d, want 24", out_q.size());
    end else begin
      for (int j = 0; j < 24; j++) begin
        n_checks++;
        if (out_q[j] != 100 + j) begin
          n_fail++;
          $display("FAIL zero_step_val[%0d]: got %0d, want %0d", j, out_q[j], 100 + j);
        end
      end
    end
  endtask

  task automatic test_down15();
    drive_line(16'd6144, 24, 2, 0, 1'b0);
    n_checks++;
    if (out_q.size() != 16) begin
      n_fail++;
      $display("FAIL down15_count: got %0d, want 16", out_q.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        n_checks++;
        if (out_q[j] != (3 * j + 1) / 2) begin
          n_fail++;
          $display("FAIL down15_val[%0d]: got %0d, want %0d", j, out_q[j], (3 * j + 1) / 2);
        end
      end
      n_checks++;
      if (ocyc_q[0] - in_cyc_q[0] != 3) begin
        n_fail++;
        $display("FAIL down15_latency: got %0d, want 3", ocyc_q[0] - in_cyc_q[0]);
      end
    end
  endtask

  task automatic test_down2();
    int s;
    s = cyc;
    drive_line(16'd8192, 24, 2, 0, 1'b1);
    n_checks++;
    if (out_q.size() != 12) begin
      n_fail++;
      $display("FAIL down2_count: got %0d, want 12", out_q.size());
    end else begin
      for (int j = 0; j < 12; j++) begin
        n_checks++;
        if (out_q[j] != 2 * j) begin
          n_fail++;
          $display("FAIL down2_val[%0d]: got %0d, want %0d", j, out_q[j], 2 * j);
        end
      end
    end
    for (int c = s + 3; c < cyc; c++) begin
      n_checks++;
      if (hs_out_h[c] != hs_in_h[c-3] || vs_out_h[c] != vs_in_h[c-3]) begin
        n_fail++;
        $display("FAIL down2_sync_delay@%0d: got hs=%0b vs=%0b, want hs=%0b vs=%0b",
                 c, hs_out_h[c], vs_out_h[c], hs_in_h[c-3], vs_in_h[c-3]);
      end
    end
  endtask

  task automatic test_up05();
    drive_line(16'd2048, 24, 2, 0, 1'b0);
    n_checks++;
    if (out_q.size() != 47) begin
      n_fail++;
      $display("FAIL up05_count: got %0d, want 47", out_q.size());
    end else begin
      for (int j = 0; j < 47; j++) begin
        n_checks++;
        if (out_q[j] != (j + 1) / 2) begin
          n_fail++;
          $display("FAIL up05_val[%0d]: got %0d, want %0d", j, out_q[j], (j + 1) / 2);
        end
      end
    end
  endtask

  task automatic test_two_frames();
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 24; l++) begin
        drive_line(16'd6144, 24, 2, l, (l == 0));
        n_checks++;
        if (out_q.size() != 16) begin
          n_fail++;
          $display("FAIL frame%0d_line%0d_count: got %0d, want 16", f, l, out_q.size());
        end else begin
          for (int j = 0; j < 16; j++) begin
            n_checks++;
            if (out_q[j] != (3 * j + 1) / 2 + l) begin
              n_fail++;
              $display("FAIL frame%0d_line%0d_val[%0d]: got %0d, want %0d",
                       f, l, j, out_q[j], (3 * j + 1) / 2 + l);
            end
          end
        end
      end
    end
  endtask

  task automatic test_midline_reset();
    scale_step = 16'd4096;
    hs_i = 1'b1;
    repeat (4) tick();
    hs_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      de_i = 1'b1;
      di_i = 8'(50 + k);
      tick();
    end
    de_i = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({do_o, de_o, hs_o, vs_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got do=%0d de=%0b hs=%0b vs=%0b, want all 0", do_o, de_o, hs_o, vs_o);
    end
    out_q.delete();
    repeat (4) tick();
    n_checks++;
    if (out_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d outputs, want 0", out_q.size());
    end
    rst = 1'b1;
    drive_line(16'd6144, 24, 2, 7, 1'b0);
    n_checks++;
    if (out_q.size() != 16) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d, want 16", out_q.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        n_checks++;
        if (out_q[j] != (3 * j + 1) / 2 + 7) begin
          n_fail++;
          $display("FAIL midreset_val[%0d]: got %0d, want %0d", j, out_q[j], (3 * j + 1) / 2 + 7);
        end
      end
    end
  endtask

  task automatic test_de_hs();
    int lim;
    lim = (cyc < HMAX) ? cyc : HMAX;
    for (int c = 0; c < lim; c++) begin
      n_checks++;
      if (de_out_h[c] && hs_out_h[c]) begin
        n_fail++;
        $display("FAIL de_during_hs@%0d: got de=1 hs=1, want de=0", c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_zero_step();
    test_down15();
    test_down2();
    test_up05();
    test_two_frames();
    test_midline_reset();
    test_de_hs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
